// File: rtl/alu_exec_pipe_pkg.sv
// alu_exec_pipe packages: sizing parameters and shared ALU command/operand types.
package parameters;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
endpackage

package common;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_cmd_t;
    typedef enum logic {OP_REG, OP_IMM} op_type_t;
endpackage

// File: rtl/alu_exec_pipe_alu.sv
// alu: purely combinational 32-bit integer ALU; unknown commands yield zero.
module alu
    import common::*;
(
    input  alu_cmd_t    cmd,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result
);
    logic [4:0] sh;
    assign sh = op2[4:0];
    always_comb begin
        result = '0;
        case (cmd)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_XOR:  result = op1 ^ op2;
            ALU_SLL:  result = op1 << sh;
            ALU_SRL:  result = op1 >> sh;
            ALU_SRA:  result = $signed(op1) >>> sh;
            ALU_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
            ALU_SLTU: result = {31'd0, op1 < op2};
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage (EX, WB) per-lane integer execute pipeline, never stalls.
// ALU_EXEC_PERF_EN adds perf counters; ALU_EXEC_SVA enables the upstream-legality assertions.
module alu_exec_pipe
    import common::*;
    import parameters::*;
(
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                flush,
    input  logic     [DISPATCH_WIDTH-1:0]                       issue_valid,
    input  alu_cmd_t [DISPATCH_WIDTH-1:0]                       issue_alu_cmd,
    input  logic     [DISPATCH_WIDTH-1:0][31:0]                 issue_op1,
    input  logic     [DISPATCH_WIDTH-1:0][31:0]                 issue_op2,
    input  op_type_t [DISPATCH_WIDTH-1:0]                       issue_op2_type,
    input  logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd,
    output logic     [DISPATCH_WIDTH-1:0]                       wb_valid,
    output logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
    output logic     [DISPATCH_WIDTH-1:0][31:0]                 wb_data,
`ifdef ALU_EXEC_PERF_EN
    output logic     [DISPATCH_WIDTH-1:0][31:0]                 perf_exec_count,
    output logic     [31:0]                                     perf_flush_drop,
`endif
    output logic                                                busy
);
    alu_cmd_t [DISPATCH_WIDTH-1:0]                           ex_cmd;
    logic     [DISPATCH_WIDTH-1:0][31:0]                     ex_op1;
    logic     [DISPATCH_WIDTH-1:0][31:0]                     ex_op2;
    logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] ex_rd;
    logic     [DISPATCH_WIDTH-1:0]                           ex_valid;
    logic     [DISPATCH_WIDTH-1:0][31:0]                     alu_res;
    logic                                                    unused_op2_type;

    // Operand-2 source is only of interest to trace tooling.
    assign unused_op2_type = ^issue_op2_type;
    assign busy = |{ex_valid, wb_valid};

    for (genvar b = 0; b < DISPATCH_WIDTH; b++) begin : g_lane
        alu u_alu (
            .cmd    (ex_cmd[b]),
            .op1    (ex_op1[b]),
            .op2    (ex_op2[b]),
            .result (alu_res[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_cmd     <= {DISPATCH_WIDTH{ALU_ADD}};
            ex_op1     <= '0;
            ex_op2     <= '0;
            ex_rd      <= '0;
            ex_valid   <= '0;
            wb_valid   <= '0;
            wb_phys_rd <= '0;
            wb_data    <= '0;
        end else begin
            for (int b = 0; b < DISPATCH_WIDTH; b++) begin
                ex_valid[b]   <= issue_valid[b] && !flush;
                wb_valid[b]   <= ex_valid[b] && !flush;
                wb_phys_rd[b] <= ex_rd[b];
                wb_data[b]    <= alu_res[b];
                if (issue_valid[b]) begin
                    ex_cmd[b] <= issue_alu_cmd[b];
                    ex_op1[b] <= issue_op1[b];
                    ex_op2[b] <= issue_op2[b];
                    ex_rd[b]  <= issue_phys_rd[b];
                end
            end
        end
    end

`ifdef ALU_EXEC_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_exec_count <= '0;
            perf_flush_drop <= '0;
        end else begin
            for (int b = 0; b < DISPATCH_WIDTH; b++)
                if (ex_valid[b] && !flush) perf_exec_count[b] <= perf_exec_count[b] + 32'd1;
            perf_flush_drop <= perf_flush_drop + (flush ? 32'($countones(ex_valid)) : 32'd0);
        end
    end
`endif

`ifdef ALU_EXEC_SVA
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < DISPATCH_WIDTH; b++) begin
                if (ex_valid[b]) assert (ex_cmd[b] <= ALU_SLTU);
                for (int c = b + 1; c < DISPATCH_WIDTH; c++)
                    if (issue_valid[b] && issue_valid[c]) assert (issue_phys_rd[b] != issue_phys_rd[c]);
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb_alu_exec_pipe: directed self-checking bench for alu_exec_pipe (perf checks under ALU_EXEC_PERF_EN).
module tb_alu_exec_pipe;
    import common::*;
    import parameters::*;

    logic                                                clk = 0;
    logic                                                rst = 0;
    logic                                                flush = 0;
    logic     [DISPATCH_WIDTH-1:0]                       issue_valid = '0;
    alu_cmd_t [DISPATCH_WIDTH-1:0]                       issue_alu_cmd = {DISPATCH_WIDTH{ALU_ADD}};
    logic     [DISPATCH_WIDTH-1:0][31:0]                 issue_op1 = '0;
    logic     [DISPATCH_WIDTH-1:0][31:0]                 issue_op2 = '0;
    op_type_t [DISPATCH_WIDTH-1:0]                       issue_op2_type = {DISPATCH_WIDTH{OP_REG}};
    logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd = '0;
    logic     [DISPATCH_WIDTH-1:0]                       wb_valid;
    logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd;
    logic     [DISPATCH_WIDTH-1:0][31:0]                 wb_data;
    logic                                                busy;
`ifdef ALU_EXEC_PERF_EN
    logic     [DISPATCH_WIDTH-1:0][31:0]                 perf_exec_count;
    logic     [31:0]                                     perf_flush_drop;
`endif

    int n_chk = 0;
    int n_fail = 0;

    alu_exec_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_alu_cmd  (issue_alu_cmd),
        .issue_op1      (issue_op1),
        .issue_op2      (issue_op2),
        .issue_op2_type (issue_op2_type),
        .issue_phys_rd  (issue_phys_rd),
        .wb_valid       (wb_valid),
        .wb_phys_rd     (wb_phys_rd),
        .wb_data        (wb_data),
`ifdef ALU_EXEC_PERF_EN
        .perf_exec_count(perf_exec_count),
        .perf_flush_drop(perf_flush_drop),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int l, input alu_cmd_t c, input logic [31:0] a, input logic [31:0] b,
                         input logic [PHYS_REGS_ADDR_WIDTH-1:0] rd);
        issue_valid[l]   = 1'b1;
        issue_alu_cmd[l] = c;
        issue_op1[l]     = a;
        issue_op2[l]     = b;
        issue_phys_rd[l] = rd;
    endtask

    alu_cmd_t    t2_c [4] = '{ALU_SUB, ALU_SRA, ALU_SLTU, ALU_SLT};
    logic [31:0] t2_a [4] = '{32'd0, 32'h8000_0000, 32'd1, 32'd1};
    logic [31:0] t2_b [4] = '{32'd1, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t2_e [4] = '{32'hFFFF_FFFF, 32'hF800_0000, 32'd1, 32'd0};
    alu_cmd_t    bad_cmd;

    initial begin
        bad_cmd = alu_cmd_t'(4'hF);
        #1 rst = 1;
        #1;
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wb_data", wb_data, 0);
        chk("reset_wb_rd", wb_phys_rd, 0);
        step();
        step();
        @(negedge clk) rst = 0;
        step();

        // single ADD on lane 0
        drive(0, ALU_ADD, 32'd5, 32'd7, 6'd3);
        step();
        issue_valid = '0;
        chk("add_ex_no_wb", wb_valid, 0);
        chk("add_ex_busy", busy, 1);
        step();
        chk("add_wb_valid", wb_valid, 2'b01);
        chk("add_wb_rd", wb_phys_rd[0], 3);
        chk("add_wb_data", wb_data[0], 12);
        step();
        chk("add_wb_once", wb_valid, 0);
        chk("add_idle_busy", busy, 0);

        // back-to-back on both lanes
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive(0, t2_c[i], t2_a[i], t2_b[i], 6'(10 + i));
                drive(1, t2_c[i], t2_a[i], t2_b[i], 6'(20 + i));
            end else issue_valid = '0;
            step();
            if (i >= 1 && i <= 4) begin
                chk("stream_valid", wb_valid, 2'b11);
                chk("stream_data0", wb_data[0], t2_e[i-1]);
                chk("stream_data1", wb_data[1], t2_e[i-1]);
                chk("stream_rd1", wb_phys_rd[1], 20 + i - 1);
            end else if (i == 5) chk("stream_drain", wb_valid, 0);
        end

        // shift amount masking and unknown command
        drive(0, ALU_SLL, 32'd1, 32'h25, 6'd5);
        drive(1, bad_cmd, 32'h1234_5678, 32'h9, 6'd6);
        step();
        issue_valid = '0;
        step();
        chk("sll_valid", wb_valid, 2'b11);
        chk("sll_data", wb_data[0], 32'h20);
        chk("unknown_data", wb_data[1], 0);
        chk("unknown_rd", wb_phys_rd[1], 6);
        step();

        // flush with an op in EX
        drive(0, ALU_XOR, 32'hF0, 32'h0F, 6'd7);
        step();
        issue_valid = '0;
        flush = 1;
        step();
        flush = 0;
        chk("flush_ex_no_wb", wb_valid, 0);
        chk("flush_ex_busy", busy, 0);
        step();
        chk("flush_ex_still_none", wb_valid, 0);

        // flush with issue 11 while an older op sits in WB
        drive(1, ALU_OR, 32'hA0, 32'h05, 6'd8);
        step();
        issue_valid = '0;
        step();
        chk("old_wb_valid", wb_valid, 2'b10);
        chk("old_wb_data", wb_data[1], 32'hA5);
        drive(0, ALU_ADD, 32'd1, 32'd1, 6'd1);
        drive(1, ALU_ADD, 32'd2, 32'd2, 6'd2);
        flush = 1;
        step();
        flush = 0;
        issue_valid = '0;
        chk("flush_issue_no_wb", wb_valid, 0);
        chk("flush_issue_busy", busy, 0);
        step();
        chk("flush_issue_still_none", wb_valid, 0);
`ifdef ALU_EXEC_PERF_EN
        chk("perf_exec0", perf_exec_count[0], 6);
        chk("perf_exec1", perf_exec_count[1], 6);
        chk("perf_drop", perf_flush_drop, 1);
`endif

        // asynchronous reset mid-cycle with ops in EX and WB
        drive(0, ALU_ADD, 32'd3, 32'd4, 6'd11);
        drive(1, ALU_ADD, 32'd5, 32'd6, 6'd12);
        step();
        drive(0, ALU_SUB, 32'd9, 32'd4, 6'd13);
        drive(1, ALU_SUB, 32'd8, 32'd2, 6'd14);
        step();
        chk("pre_rst_valid", wb_valid, 2'b11);
        #2 rst = 1;
        #1;
        chk("async_rst_valid", wb_valid, 0);
        chk("async_rst_busy", busy, 0);
`ifdef ALU_EXEC_PERF_EN
        chk("async_rst_perf", perf_flush_drop, 0);
`endif
        #1 rst = 0;
        issue_valid = '0;
        step();
        chk("post_rst_idle", wb_valid, 0);
        drive(1, ALU_ADD, 32'd100, 32'd23, 6'd9);
        step();
        issue_valid = '0;
        step();
        chk("post_rst_valid", wb_valid, 2'b10);
        chk("post_rst_rd", wb_phys_rd[1], 9);
        chk("post_rst_data", wb_data[1], 123);
        step();
        chk("post_rst_once", wb_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_pipe.md
# alu_exec_pipe

Two-stage integer execute pipeline directly downstream of the issue queue. Each cycle it accepts up to DISPATCH_WIDTH ready micro-ops from the issue port, computes the ALU result in an execute stage, and registers it into a writeback stage. The writeback stage drives the issue-queue wakeup/writeback port and the physical register file write port. It never back-pressures: every valid issue is accepted.

## Interface
- DISPATCH_WIDTH, 2, number of parallel lanes (banks); equals the issue width.
- PHYS_REGS_ADDR_WIDTH, from parameters package, physical register index width.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  squash all in-flight ops (branch mispredict/exception).
- issue_valid  input  DISPATCH_WIDTH  per-lane op valid.
- issue_alu_cmd  input  DISPATCH_WIDTH x common::alu_cmd_t  operation.
- issue_op1  input  DISPATCH_WIDTH x 32  operand 1 value.
- issue_op2  input  DISPATCH_WIDTH x 32  operand 2 value (register data or immediate).
- issue_op2_type  input  DISPATCH_WIDTH x common::op_type_t  operand 2 source; carried for trace only.
- issue_phys_rd  input  DISPATCH_WIDTH x PHYS_REGS_ADDR_WIDTH  destination.
- wb_valid  output  DISPATCH_WIDTH  result valid.
- wb_phys_rd  output  DISPATCH_WIDTH x PHYS_REGS_ADDR_WIDTH  result destination.
- wb_data  output  DISPATCH_WIDTH x 32  result.
- busy  output  1  OR of all EX and WB valids.

## Operation
- Lanes are independent and identical. Per lane there are two registers: EX (cmd, op1, op2, phys_rd, valid) and WB (phys_rd, data, valid).
- Accept: when issue_valid[b] is high and flush is low, the EX register of lane b loads the issue fields at the edge. Otherwise EX valid clears.
- Execute: a combinational ALU operates on the EX register contents. ADD = op1+op2. SUB = op1-op2. AND, OR, XOR are bitwise.
- Shifts: SLL, SRL and SRA shift by op2[4:0]; SRA is arithmetic.
- Compares: SLT is a signed compare and SLTU is unsigned; the result is zero-extended to 32 bits.
- Arithmetic is mod 2^32 with no overflow flag.
- An unknown cmd produces 0. When SVA is enabled, an assertion also fires.
- Writeback: the WB register loads the ALU result, EX phys_rd and EX valid. If flush is high in that cycle, WB valid clears instead.
- Outputs are driven directly from the WB register.
- Any data and phys_rd value is allowed when valid is low; the bench checks them only when valid is high.
- Duplicate phys_rd across lanes in the same cycle is illegal upstream. An assertion checks for it, and the behaviour is not defined.
- Physical register 0 is not special-cased.

## Timing
- Latency is 2 cycles: an issue sampled at edge t appears on wb_* after edge t+1 and stays valid for exactly one cycle.
- Throughput is one op per lane per cycle, with no bubbles and no stalls.
- Reset clears every EX and WB valid immediately (asynchronously).
- Reset values of the outputs: wb_valid=0, wb_phys_rd=0, wb_data=0, busy=0.
- Reset that arrives mid-operation drops all in-flight ops, with no partial writeback.
- Flush sampled at edge t:
  - ops issued in the same cycle are dropped;
  - ops in EX are dropped;
  - ops in WB at edge t, whose wb_valid is visible during the flush cycle, have already been reported and are not retracted;
  - wb_valid=0 in the cycle after the flush edge.
- Flush and issue in the same cycle: flush wins.

## Configuration
- ALU_EXEC_PERF_EN, when defined, adds:
  - 32-bit per-lane counters of completed ops, output perf_exec_count (DISPATCH_WIDTH x 32);
  - a 32-bit count of flushed valid EX ops, output perf_flush_drop.
- Counter rules: counters are cleared by rst, wrap at 2^32, and increment on the edge where the WB/flush event occurs.
- When ALU_EXEC_PERF_EN is undefined, those ports and counters are absent and the remaining behaviour is identical.

## Structure
- The common package holds alu_cmd_t (including the encodings of ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU) and op_type_t.
- The parameters package holds DISPATCH_WIDTH and PHYS_REGS_ADDR_WIDTH.
- One sub-module, alu, is purely combinational (cmd, op1, op2 → result) and is instantiated once per lane.

## Test plan
- Lane 0 issues ADD 5+7 to phys_rd 3 at cycle 0 → wb_valid[0]=1, wb_phys_rd=3, wb_data=12 in cycle 2 only.
- Both lanes every cycle for 4 cycles run SUB 0-1, SRA 0x80000000>>4, SLTU 1<0xFFFFFFFF, SLT 1<0xFFFFFFFF → wb_data=0xFFFFFFFF, 0xF8000000, 1, 0, in order, with no bubbles.
- Flush in the cycle after an issue (op in EX) → no wb_valid. With ALU_EXEC_PERF_EN, perf_flush_drop increments by 1.
- Flush asserted in the same cycle as issue_valid=2'b11 → no writeback. An op already in WB still appears exactly once.
- rst asserted asynchronously mid-cycle with ops in both stages → wb_valid and busy drop to 0 before the next edge. After release, a new issue writes back normally after 2 cycles.
- SLL with op2=0x25 (shift 5) on op1=1 → 0x20. An unknown cmd → 0 and an assertion is flagged.
